uart_tx_mmio: RTL and testbench
===============================

# uart_tx_mmio

Memory-mapped UART transmitter on the SOPC data bus, alongside `data_ram`, selected by the top-level address decode. The core writes bytes into an 8-entry FIFO through the same `ce/we/sel/addr/data` handshake it uses for data RAM. A TX state machine serialises them as 8N1 frames on `txd`. A level interrupt drives one of the core's spare `int_i[5:1]` lines when the transmitter drains.

## Interface
- `CLK_DIV`, 434, clock cycles per serial bit (50 MHz / 115200); legal range 2..65535
- `FIFO_DEPTH`, 8, TX FIFO entries; power of two, 2..16

- `clk`  input  1  system clock, all logic on rising edge
- `rst`  input  1  synchronous, active-high reset
- `ce`  input  1  chip enable from bus decode
- `we`  input  1  write enable (1 = write, 0 = read)
- `sel`  input  4  byte lanes; `sel[0]` qualifies every register write
- `addr`  input  32  byte address; only `addr[3:2]` decoded
- `data_i`  input  32  write data
- `data_o`  output  32  read data, combinational
- `txd`  output  1  serial line, idle high
- `int_o`  output  1  level interrupt to core

## Operation
- Register map (`addr[3:2]`):
  - 0 TXDATA: write pushes `data_i[7:0]`; reads 0
  - 1 STATUS, read-only:
    - bit0 busy (FSM not IDLE)
    - bit1 full
    - bit2 empty
    - bit3 overflow (sticky)
    - bits[7:4] FIFO count
    - rest 0
  - 2 CTRL: bit0 irq_en (r/w); writing bit1=1 clears overflow (bit1 reads 0)
  - 3: reserved; writes ignored, reads 0
- Write takes effect when `ce & we & sel[0]` at the clock edge; `sel[3:1]` ignored.
- `data_o` = selected register when `ce & ~we`, else 0.
- FIFO:
  - Push when a TXDATA write is accepted.
  - Fullness is judged on the pre-edge count. A push while full is dropped and sets overflow, even if a pop occurs on the same edge.
- TX FSM states: IDLE, START, DATA, STOP.
- 16-bit baud counter; each state lasts exactly `CLK_DIV` cycles.
- Transitions:
  - IDLE:
    - FIFO non-empty: pop head into shift register, clear bit index, go to START.
    - Otherwise `txd` = 1.
  - START: `txd` = 0 → DATA.
  - DATA: `txd` = shift[0], LSB first. After each bit period, shift right and increment index; after bit 7 → STOP.
  - STOP: `txd` = 1. At end of period:
    - FIFO non-empty: pop and go directly to START (back-to-back, no idle gap).
    - Otherwise → IDLE.
- `int_o` = irq_en & empty & ~busy (level). It falls when a byte is pushed or irq_en is cleared.

## Timing
- Reset (synchronous, `rst`=1 at an edge):
  - FSM to IDLE, FIFO emptied, counters zero, irq_en=0, overflow=0.
  - `txd`=1, `int_o`=0.
  - `data_o`=0 unless a read is presented.
- Reset mid-frame aborts the frame immediately: `txd`=1 from the reset edge. The partial frame is lost, and the FIFO contents are discarded.
- Write-to-line latency: TXDATA written at edge k while idle and empty:
  - count=1 after k
  - pop at edge k+1
  - `txd` falls after k+1
- Frame length: exactly 10·`CLK_DIV` cycles from `txd` fall to the end of the stop bit.
- Back-to-back frames: next start bit begins on the cycle after the prior stop bit's last cycle.
- STATUS reflects registered state. A read in the same cycle as a write returns pre-write values.
- `int_o` is registered-state combinational: it asserts the cycle after the STOP→IDLE edge, provided irq_en=1 and FIFO empty.
- No wait states; every bus access completes in one cycle.

## Test plan
- Reset: hold `rst` 2 cycles.
  - `txd`=1, `int_o`=0.
  - STATUS read = 0x0000_0004 (empty only).
- Single byte, `CLK_DIV`=4: write 0x55 to TXDATA.
  - `txd` falls one cycle after the write edge, then runs 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles.
  - Total 40 cycles, then idle high.
  - STATUS busy=1 throughout, 0 after.
- Back-to-back: write 0xA5, 0x3C, 0xFF in consecutive cycles.
  - STATUS count peaks at 2 after the first pop.
  - Three frames of 40 cycles with no gap between stop and next start.
  - Bit order LSB first per frame.
- Overflow: with the line busy, write 9 bytes (`FIFO_DEPTH`=8).
  - STATUS shows full=1, count=8, overflow=1.
  - 9th byte never transmitted.
  - CTRL write 0x2 clears overflow; irq_en stays 0.
- Interrupt: CTRL=1, write 0x81.
  - `int_o`=0 during the frame; rises one cycle after the stop bit ends.
  - Writing another byte drops `int_o` the next cycle.
  - CTRL=0 also drops it.
- Reset mid-frame: assert `rst` during data bit 3 with 2 bytes queued.
  - `txd`=1 from the reset edge, STATUS=0x4.
  - No further frames are sent.

Source files
------------

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: bus-mapped 8N1 UART transmitter with a small TX FIFO and drain interrupt.
module uart_tx_mmio #(
  parameter int unsigned CLK_DIV    = 434,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [3:0]  sel,
  input  logic [31:0] addr,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        txd,
  output logic        int_o
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = 16;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [7:0]    shift, shift_n;
  logic [2:0]    idx, idx_n;
  logic [BW-1:0] baud, baud_n;
  logic          txd_n;
  logic          pop;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty;
  logic          irq_en, overflow;
  logic          wr_acc, push_req, push;
  logic          busy, baud_end;
  logic          unused_bits;

  // Bus decode and FIFO status flags.
  always_comb begin
    wr_acc   = ce & we & sel[0];
    push_req = wr_acc && (addr[3:2] == REG_TXDATA);
    full     = (count == CW'(FIFO_DEPTH));
    empty    = (count == '0);
    push     = push_req & ~full;
    busy     = (state != IDLE);
    baud_end = (baud == BW'(CLK_DIV - 1));
  end

  // Next-state, shift/baud datapath and next line level for the TX FSM.
  always_comb begin
    state_n = state;
    shift_n = shift;
    idx_n   = idx;
    baud_n  = baud;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        baud_n = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          idx_n   = '0;
          state_n = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_n  = '0;
          state_n = DATA;
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_n  = '0;
          shift_n = {1'b0, shift[7:1]};
          idx_n   = idx + 3'd1;
          if (idx == 3'd7) state_n = STOP;
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_n = '0;
          if (!empty) begin
            // Back-to-back: next start bit follows the stop bit directly.
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            idx_n   = '0;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = shift_n[0];
      default: txd_n = 1'b1;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Shift register, bit index, baud counter and registered line output.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift <= '0;
      idx   <= '0;
      baud  <= '0;
      txd   <= 1'b1;
    end else begin
      shift <= shift_n;
      idx   <= idx_n;
      baud  <= baud_n;
      txd   <= txd_n;
    end
  end

  // FIFO pointers and occupancy; pushes while full are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_i[7:0];
  end

  // Control register and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_acc && (addr[3:2] == REG_CTRL)) begin
        irq_en <= data_i[0];
        if (data_i[1]) overflow <= 1'b0;
      end
      if (push_req && full) overflow <= 1'b1;
    end
  end

  // Drain interrupt: enabled, nothing queued and the line has gone idle.
  assign int_o = irq_en & empty & ~busy;

  // Combinational read mux; count field is four bits wide.
  always_comb begin
    data_o = '0;
    if (ce && !we) begin
      case (addr[3:2])
        REG_STATUS: data_o = {24'b0, 4'(count), overflow, empty, full, busy};
        REG_CTRL:   data_o = {31'b0, irq_en};
        default:    data_o = '0;
      endcase
    end
  end

  assign unused_bits = ^{addr[31:4], addr[1:0], sel[3:1], data_i[31:8]};

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: random and directed bus traffic checked every cycle against a frame-timeline model.
module tb_uart_tx_mmio;

  localparam int unsigned DIV   = 4;
  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst, ce, we;
  logic [3:0]  sel;
  logic [31:0] addr, data_i, data_o;
  logic        txd, int_o;

  always #5 clk = ~clk;

  uart_tx_mmio #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .sel(sel), .addr(addr),
    .data_i(data_i), .data_o(data_o), .txd(txd), .int_o(int_o)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] last_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: byte queue, current frame byte and the edge on which it started.
  byte unsigned m_q[$];
  bit           m_active;
  bit [7:0]     m_cur;
  int           m_start;
  int           m_edge = 0;
  bit           m_ovf, m_irq;

  function automatic bit exp_txd();
    int k;
    if (!m_active) return 1'b1;
    k = (m_edge - m_start) / int'(DIV);
    if (k == 0) return 1'b0;
    if (k <= 8) return m_cur[k-1];
    return 1'b1;
  endfunction

  function automatic bit exp_int();
    return m_irq && (m_q.size() == 0) && !m_active;
  endfunction

  function automatic logic [31:0] exp_read(input logic c, input logic w, input logic [31:0] a);
    logic [31:0] v;
    v = '0;
    if (c && !w) begin
      case (a[3:2])
        2'd1: v = {24'b0, 4'(m_q.size()), m_ovf, m_q.size() == 0,
                   m_q.size() == int'(DEPTH), m_active};
        2'd2: v = {31'b0, m_irq};
        default: v = '0;
      endcase
    end
    return v;
  endfunction

  task automatic model_edge(input logic r, input logic c, input logic w, input logic [3:0] s,
                            input logic [31:0] a, input logic [31:0] d);
    int pre;
    bit free;
    m_edge++;
    if (r) begin
      m_q.delete();
      m_active = 0;
      m_ovf    = 0;
      m_irq    = 0;
      return;
    end
    pre  = m_q.size();
    free = !m_active || (m_edge == m_start + 10 * int'(DIV));
    if (free) begin
      if (pre > 0) begin
        m_cur    = m_q.pop_front();
        m_start  = m_edge;
        m_active = 1;
      end else begin
        m_active = 0;
      end
    end
    if (c && w && s[0]) begin
      case (a[3:2])
        2'd0: if (pre == int'(DEPTH)) m_ovf = 1; else m_q.push_back(d[7:0]);
        2'd2: begin
          m_irq = d[0];
          if (d[1]) m_ovf = 0;
        end
        default: ;
      endcase
    end
  endtask

  // One bus cycle: drive, check outputs mid-cycle, then advance the model on the edge.
  task automatic cyc(input logic r, input logic c, input logic w, input logic [3:0] s,
                     input logic [31:0] a, input logic [31:0] d);
    rst = r; ce = c; we = w; sel = s; addr = a; data_i = d;
    @(negedge clk);
    check("txd", 32'(txd), 32'(exp_txd()));
    check("int_o", 32'(int_o), 32'(exp_int()));
    check("data_o", data_o, exp_read(c, w, a));
    last_rd = data_o;
    @(posedge clk);
    model_edge(r, c, w, s, a, d);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(1'b0, 1'b1, 1'b1, 4'hF, a, d);
  endtask

  task automatic rd(input logic [31:0] a);
    cyc(1'b0, 1'b1, 1'b0, 4'h0, a, 32'hDEAD_BEEF);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) rd(32'h4);
  endtask

  logic [31:0] r32, d32;
  int unsigned p, wp;

  initial begin
    rst = 1'b1; ce = 1'b0; we = 1'b0; sel = '0; addr = '0; data_i = '0;
    @(posedge clk);
    model_edge(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    rd(32'h4);
    check("rst_status", last_rd, 32'h4);

    // Single byte frame.
    wr(32'h0, 32'h55);
    idle(45);
    check("single_idle_status", last_rd, 32'h4);

    // Back-to-back frames.
    wr(32'h0, 32'hA5);
    wr(32'h0, 32'h3C);
    wr(32'h0, 32'hFF);
    idle(125);
    check("b2b_idle_status", last_rd, 32'h4);

    // Overflow while the line is busy.
    wr(32'h0, 32'h11);
    idle(2);
    for (int i = 0; i < 9; i++) wr(32'h0, 32'(8'h20 + i));
    rd(32'h4);
    check("ovf_status", last_rd, 32'h8B);
    wr(32'h8, 32'h2);
    rd(32'h8);
    check("ovf_ctrl_irq", last_rd, 32'h0);
    rd(32'h4);
    check("ovf_cleared", last_rd, 32'h83);
    idle(400);
    check("ovf_drained", last_rd, 32'h4);

    // Drain interrupt.
    wr(32'h8, 32'h1);
    wr(32'h0, 32'h81);
    idle(45);
    check("irq_high", 32'(int_o), 32'h1);
    wr(32'h0, 32'h42);
    idle(45);
    wr(32'h8, 32'h0);
    idle(2);
    check("irq_low", 32'(int_o), 32'h0);

    // Reset during data bit 3 with two bytes queued.
    wr(32'h0, 32'h12);
    wr(32'h0, 32'h34);
    wr(32'h0, 32'h56);
    idle(16);
    cyc(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    rd(32'h4);
    check("midreset_status", last_rd, 32'h4);
    idle(60);

    // Randomised traffic, alternating light and heavy write load.
    for (int i = 0; i < 4000; i++) begin
      p   = $urandom_range(0, 999);
      r32 = $urandom;
      d32 = $urandom;
      wp  = ((i / 500) % 2 == 0) ? 30 : 150;
      if (p < 3)
        cyc(1'b1, r32[4], r32[5], r32[9:6], r32, d32);
      else if (p < 3 + wp)
        cyc(1'b0, 1'b1, 1'b1, {r32[3:1], 1'b1}, {r32[31:4], 2'd0, r32[1:0]}, d32);
      else if (p < 63 + wp)
        cyc(1'b0, 1'b1, 1'b1, {r32[3:1], 1'b1}, {r32[31:4], 2'd2, r32[1:0]}, d32);
      else if (p < 103 + wp)
        cyc(1'b0, 1'b1, 1'b1, r32[7:4], r32, d32);
      else if (p < 303 + wp)
        cyc(1'b0, 1'b1, 1'b0, r32[7:4], r32, d32);
      else
        cyc(1'b0, 1'b0, r32[8], r32[7:4], r32, d32);
    end
    idle(500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
